// File: rtl/comm_message_receiver_if.sv
// Message bundle between the pong link receiver and gameStateModule.
// master drives the decoded message; slave returns the ack.
interface comm_message_receiver_if;
   logic       new_message_received;
   logic       message_acked;
   logic       ball_message_rx;
   logic       miss_message_rx;
   logic       new_game_message_rx;
   logic       new_game_ack_message_rx;
   logic [8:0] ball_y_rx;
   logic [3:0] velocity_x_rx;
   logic [3:0] velocity_y_rx;
   logic [4:0] my_score_rx;
   logic [4:0] your_score_rx;
   logic       you_should_serve_rx;
   logic       you_serve_first_rx;
   logic       rx_busy;

   modport master (
      output new_message_received,
      input  message_acked,
      output ball_message_rx,
      output miss_message_rx,
      output new_game_message_rx,
      output new_game_ack_message_rx,
      output ball_y_rx,
      output velocity_x_rx,
      output velocity_y_rx,
      output my_score_rx,
      output your_score_rx,
      output you_should_serve_rx,
      output you_serve_first_rx,
      output rx_busy
   );

   modport slave (
      input  new_message_received,
      output message_acked,
      input  ball_message_rx,
      input  miss_message_rx,
      input  new_game_message_rx,
      input  new_game_ack_message_rx,
      input  ball_y_rx,
      input  velocity_x_rx,
      input  velocity_y_rx,
      input  my_score_rx,
      input  your_score_rx,
      input  you_should_serve_rx,
      input  you_serve_first_rx,
      input  rx_busy
   );
endinterface

// File: rtl/comm_message_receiver.sv
// Pong link receiver: 8N1 UART, 5-byte frame parser, held message output.
// Define COMM_RX_STATS_EN to add frame_err_count / overrun_count ports.
module comm_message_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic clock,
   input  logic reset_L,
   input  logic UART_RXD,
   comm_message_receiver_if.master msg
`ifdef COMM_RX_STATS_EN
   ,
   output logic [7:0] frame_err_count,
   output logic [7:0] overrun_count
`endif
);

   localparam int HALF     = CLKS_PER_BIT / 2;
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int TW       = $clog2(TO_LIMIT);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

   typedef enum logic [1:0] {
      U_IDLE, U_START, U_DATA, U_STOP
   } uart_state_t;

   typedef enum logic [2:0] {
      P_HUNT, P_PAY1, P_PAY2, P_PAY3, P_CSUM
   } parse_state_t;

   typedef struct packed {
      logic       ball;
      logic       miss;
      logic       new_game;
      logic       ack;
      logic [8:0] ball_y;
      logic [3:0] vel_x;
      logic [3:0] vel_y;
      logic [4:0] my_score;
      logic [4:0] your_score;
      logic       serve;
      logic       serve_first;
   } msg_t;

   logic rxd_meta;
   logic rxd_sync;
   logic rxd_prev;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= UART_RXD;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   uart_state_t   u_state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [7:0]    rx_byte;
   logic          byte_valid;
   logic          frame_err;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         u_state    <= U_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         unique case (u_state)
            U_IDLE: begin
               if (rxd_prev && !rxd_sync) begin
                  u_state <= U_START;
                  bit_cnt <= '0;
               end
            end
            U_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  u_state <= rxd_sync ? U_IDLE : U_DATA;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            U_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shreg   <= {rxd_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     u_state <= U_STOP;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            U_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  u_state <= U_IDLE;
                  if (rxd_sync) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= shreg;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            default: u_state <= U_IDLE;
         endcase
      end
   end

   parse_state_t  p_state;
   logic [1:0]    f_type;
   logic [16:0]   payload;
   logic [7:0]    csum;
   logic [TW-1:0] to_cnt;
   logic          commit_pend;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         p_state     <= P_HUNT;
         f_type      <= '0;
         payload     <= '0;
         csum        <= '0;
         to_cnt      <= '0;
         commit_pend <= 1'b0;
      end else begin
         commit_pend <= 1'b0;
         if (frame_err) begin
            p_state <= P_HUNT;
            to_cnt  <= '0;
         end else if (byte_valid) begin
            to_cnt <= '0;
            unique case (p_state)
               P_HUNT: begin
                  if (rx_byte[7:2] == 6'b101000) begin
                     f_type  <= rx_byte[1:0];
                     csum    <= rx_byte;
                     p_state <= P_PAY1;
                  end
               end
               P_PAY1: begin
                  payload[16] <= rx_byte[0];
                  csum        <= csum ^ rx_byte;
                  p_state     <= P_PAY2;
               end
               P_PAY2: begin
                  payload[15:8] <= rx_byte;
                  csum          <= csum ^ rx_byte;
                  p_state       <= P_PAY3;
               end
               P_PAY3: begin
                  payload[7:0] <= rx_byte;
                  csum         <= csum ^ rx_byte;
                  p_state      <= P_CSUM;
               end
               P_CSUM: begin
                  p_state     <= P_HUNT;
                  commit_pend <= (rx_byte == csum);
               end
               default: p_state <= P_HUNT;
            endcase
         end else if (p_state != P_HUNT) begin
            if (to_cnt == TO_LAST) begin
               p_state <= P_HUNT;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end
      end
   end

   msg_t dec;

   always_comb begin
      dec = '0;
      unique case (1'b1)
         f_type == 2'd0: begin
            dec.ball   = 1'b1;
            dec.ball_y = payload[16:8];
            dec.vel_x  = payload[7:4];
            dec.vel_y  = payload[3:0];
         end
         f_type == 2'd1: begin
            dec.miss       = 1'b1;
            dec.my_score   = payload[10:6];
            dec.your_score = payload[5:1];
            dec.serve      = payload[0];
         end
         f_type == 2'd2: begin
            dec.new_game    = 1'b1;
            dec.serve_first = payload[0];
         end
         default: dec.ack = 1'b1;
      endcase
   end

   msg_t msg_q;
   logic holding;
   logic ack;
   logic load;

   // An ack in the commit cycle frees the slot before the new frame lands.
   assign ack  = holding && msg.message_acked;
   assign load = commit_pend && (!holding || ack);

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         holding <= 1'b0;
         msg_q   <= '0;
      end else begin
         if (ack) begin
            holding        <= 1'b0;
            msg_q.ball     <= 1'b0;
            msg_q.miss     <= 1'b0;
            msg_q.new_game <= 1'b0;
            msg_q.ack      <= 1'b0;
         end
         if (load) begin
            holding <= 1'b1;
            msg_q   <= dec;
         end
      end
   end

   assign msg.new_message_received    = holding;
   assign msg.rx_busy                 = holding;
   assign msg.ball_message_rx         = msg_q.ball;
   assign msg.miss_message_rx         = msg_q.miss;
   assign msg.new_game_message_rx     = msg_q.new_game;
   assign msg.new_game_ack_message_rx = msg_q.ack;
   assign msg.ball_y_rx               = msg_q.ball_y;
   assign msg.velocity_x_rx           = msg_q.vel_x;
   assign msg.velocity_y_rx           = msg_q.vel_y;
   assign msg.my_score_rx             = msg_q.my_score;
   assign msg.your_score_rx           = msg_q.your_score;
   assign msg.you_should_serve_rx     = msg_q.serve;
   assign msg.you_serve_first_rx      = msg_q.serve_first;

`ifdef COMM_RX_STATS_EN
   logic csum_bad;
   logic to_hit;
   logic err_evt;
   logic ovr_evt;

   assign csum_bad = byte_valid && (p_state == P_CSUM)
                     && (rx_byte != csum);
   assign to_hit   = !frame_err && !byte_valid
                     && (p_state != P_HUNT) && (to_cnt == TO_LAST);
   assign err_evt  = frame_err || csum_bad || to_hit;
   assign ovr_evt  = commit_pend && holding && !ack;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         frame_err_count <= '0;
         overrun_count   <= '0;
      end else begin
         if (err_evt && frame_err_count != 8'hFF)
            frame_err_count <= frame_err_count + 8'd1;
         if (ovr_evt && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_comm_message_receiver.sv
// Random and directed frames against a byte-queue model of the receiver.
module tb_comm_message_receiver;

   localparam int CPB = 4;

   logic clock;
   logic reset_L;
   logic UART_RXD;

   comm_message_receiver_if bus();

`ifdef COMM_RX_STATS_EN
   logic [7:0] frame_err_count;
   logic [7:0] overrun_count;
`endif

   comm_message_receiver #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_BITS(20)
   ) dut (
      .clock(clock),
      .reset_L(reset_L),
      .UART_RXD(UART_RXD),
      .msg(bus.master)
`ifdef COMM_RX_STATS_EN
      ,
      .frame_err_count(frame_err_count),
      .overrun_count(overrun_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       nmr;
      logic       busy;
      logic       ball;
      logic       miss;
      logic       ng;
      logic       nga;
      logic [8:0] y;
      logic [3:0] vx;
      logic [3:0] vy;
      logic [4:0] my;
      logic [4:0] your;
      logic       serve;
      logic       first;
   } obs_t;

   obs_t       m;
   logic [7:0] q[$];
   int         m_err;
   int         m_ovr;
   int         n_checks;
   int         n_err;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.nmr   = bus.new_message_received;
      o.busy  = bus.rx_busy;
      o.ball  = bus.ball_message_rx;
      o.miss  = bus.miss_message_rx;
      o.ng    = bus.new_game_message_rx;
      o.nga   = bus.new_game_ack_message_rx;
      o.y     = bus.ball_y_rx;
      o.vx    = bus.velocity_x_rx;
      o.vy    = bus.velocity_y_rx;
      o.my    = bus.my_score_rx;
      o.your  = bus.your_score_rx;
      o.serve = bus.you_should_serve_rx;
      o.first = bus.you_serve_first_rx;
      return o;
   endfunction

   task automatic check_msg(input string tag);
      check(tag, 64'(observe()), 64'(m));
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

`ifdef COMM_RX_STATS_EN
   task automatic check_stats(input string tag);
      check({tag, "_errcnt"}, 64'(frame_err_count), 64'(sat(m_err)));
      check({tag, "_ovrcnt"}, 64'(overrun_count), 64'(sat(m_ovr)));
   endtask
`endif

   // Reference model: works on whole bytes and frames, no timing.
   task automatic model_reset();
      m = '0;
      q.delete();
      m_err = 0;
      m_ovr = 0;
   endtask

   task automatic model_commit(input int t, input int pv);
      if (m.nmr) begin
         m_ovr++;
      end else begin
         m      = '0;
         m.nmr  = 1'b1;
         m.busy = 1'b1;
         case (t)
            0: begin
               m.ball = 1'b1;
               m.y    = 9'((pv / 256) % 512);
               m.vx   = 4'((pv / 16) % 16);
               m.vy   = 4'(pv % 16);
            end
            1: begin
               m.miss  = 1'b1;
               m.my    = 5'((pv / 64) % 32);
               m.your  = 5'((pv / 2) % 32);
               m.serve = 1'(pv % 2);
            end
            2: begin
               m.ng    = 1'b1;
               m.first = 1'(pv % 2);
            end
            default: m.nga = 1'b1;
         endcase
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] h;
      if (q.size() == 0) begin
         if (b[7:2] == 6'b101000)
            q.push_back(b);
      end else begin
         q.push_back(b);
         if (q.size() == 5) begin
            h = q[0];
            if ((q[0] ^ q[1] ^ q[2] ^ q[3]) == q[4])
               model_commit(int'(h[1:0]),
                            int'({q[1], q[2], q[3]}));
            else
               m_err++;
            q.delete();
         end
      end
   endtask

   task automatic model_ferr();
      q.delete();
      m_err++;
   endtask

   task automatic model_gap();
      if (q.size() != 0) begin
         q.delete();
         m_err++;
      end
   endtask

   task automatic model_ack();
      if (m.nmr) begin
         m.nmr  = 1'b0;
         m.busy = 1'b0;
         m.ball = 1'b0;
         m.miss = 1'b0;
         m.ng   = 1'b0;
         m.nga  = 1'b0;
      end
   endtask

   // Stimulus
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wire_byte(input logic [7:0] b, input logic stop);
      UART_RXD = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         UART_RXD = b[i];
         repeat (CPB) tick();
      end
      UART_RXD = stop;
      repeat (CPB) tick();
      UART_RXD = 1'b1;
      if (!stop)
         repeat (CPB) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      wire_byte(b, 1'b1);
      model_byte(b);
   endtask

   task automatic send_bad_stop(input logic [7:0] b);
      wire_byte(b, 1'b0);
      model_ferr();
   endtask

   task automatic idle_gap(input int bits);
      repeat (bits * CPB) tick();
      model_gap();
   endtask

   function automatic logic [7:0] cs(input logic [7:0] h, p1, p2, p3);
      return h ^ p1 ^ p2 ^ p3;
   endfunction

   task automatic send_frame(input logic [7:0] h, p1, p2, p3, c);
      send_byte(h);
      send_byte(p1);
      send_byte(p2);
      send_byte(p3);
      send_byte(c);
      repeat (4) tick();
   endtask

   // Ack raised so it is sampled k cycles after the C byte's stop bit ends;
   // k=2 lands exactly on the commit cycle, k=3 one cycle later.
   task automatic send_frame_ack(input logic [7:0] h, p1, p2, p3,
                                 input int k);
      logic [7:0] c;
      c = cs(h, p1, p2, p3);
      send_byte(h);
      send_byte(p1);
      send_byte(p2);
      send_byte(p3);
      wire_byte(c, 1'b1);
      repeat (k) tick();
      bus.message_acked = 1'b1;
      if (k <= 2) begin
         model_ack();
         model_byte(c);
      end else begin
         model_byte(c);
         model_ack();
      end
      tick();
      bus.message_acked = 1'b0;
   endtask

   task automatic ack_pulse();
      bus.message_acked = 1'b1;
      tick();
      bus.message_acked = 1'b0;
      model_ack();
   endtask

   logic [7:0]  fb[5];
   logic [7:0]  bad;
   logic [23:0] p;
   int          t;
   int          mode;
   int          idx;

   initial begin
      n_checks = 0;
      n_err    = 0;
      reset_L  = 1'b0;
      UART_RXD = 1'b1;
      bus.message_acked = 1'b0;
      model_reset();
      #1;
      check_msg("reset");
      repeat (3) tick();
      reset_L = 1'b1;
      repeat (4) tick();

      send_frame(8'hA0, 8'h01, 8'h2C, 8'h3E, 8'h73);
      check_msg("t1_badcs");
      send_frame(8'hA0, 8'h01, 8'h2C, 8'h3E,
                 cs(8'hA0, 8'h01, 8'h2C, 8'h3E));
      check_msg("t1_ball");
      repeat (20) tick();
      check_msg("t1_hold");
      ack_pulse();
      check_msg("t1_ack");

      send_frame(8'hA1, 8'h00, 8'h01, 8'h4B, 8'hEB);
      check_msg("t2_miss");
      ack_pulse();
      check_msg("t2_ack");

      send_frame(8'hA2, 8'h00, 8'h00, 8'h01, 8'hA2);
      check_msg("t3_badcs");
      send_frame(8'hA2, 8'h00, 8'h00, 8'h01, 8'hA3);
      check_msg("t3_newgame");
      ack_pulse();
      ack_pulse();
      check_msg("t3_idle_ack");

      send_frame(8'hA0, 8'h00, 8'h55, 8'h97,
                 cs(8'hA0, 8'h00, 8'h55, 8'h97));
      check_msg("t4_f1");
      send_frame(8'hA1, 8'h00, 8'h03, 8'hFF,
                 cs(8'hA1, 8'h00, 8'h03, 8'hFF));
      check_msg("t4_overrun");
      send_frame_ack(8'hA2, 8'h00, 8'h00, 8'h01, 2);
      check_msg("t4_ack_commit");
      send_frame_ack(8'hA1, 8'h00, 8'h02, 8'h41, 3);
      check_msg("t4_ack_late");

      send_bad_stop(8'hA0);
      send_frame(8'hA3, 8'h00, 8'h00, 8'h00, 8'hA3);
      check_msg("t5_ackmsg");
      ack_pulse();

      send_byte(8'hA0);
      send_byte(8'h01);
      idle_gap(21);
      send_byte(8'h2C);
      send_byte(8'h3E);
      send_byte(cs(8'hA0, 8'h01, 8'h2C, 8'h3E));
      repeat (4) tick();
      check_msg("t6_timeout");
`ifdef COMM_RX_STATS_EN
      check_stats("pre_reset");
`endif

      send_frame(8'hA1, 8'h00, 8'h07, 8'hC1,
                 cs(8'hA1, 8'h00, 8'h07, 8'hC1));
      check_msg("t6_held");
      send_byte(8'hA0);
      send_byte(8'h01);
      UART_RXD = 1'b0;
      repeat (10) tick();
      reset_L = 1'b0;
      #1;
      model_reset();
      check_msg("t6_reset");
      UART_RXD = 1'b1;
      repeat (3) tick();
      reset_L = 1'b1;
      repeat (4) tick();
      send_frame(8'hA0, 8'h01, 8'hF0, 8'h5A,
                 cs(8'hA0, 8'h01, 8'hF0, 8'h5A));
      check_msg("t6_after_reset");
      ack_pulse();
      check_msg("t6_after_ack");

      for (int it = 0; it < 24; it++) begin
         t     = $urandom_range(0, 3);
         p     = 24'($urandom);
         fb[0] = {6'b101000, 2'(t)};
         fb[1] = p[23:16];
         fb[2] = p[15:8];
         fb[3] = p[7:0];
         fb[4] = cs(fb[0], fb[1], fb[2], fb[3]);
         mode  = $urandom_range(0, 6);
         idx   = $urandom_range(0, 3);
         if (mode == 3)
            fb[4] = fb[4] ^ 8'(1 << $urandom_range(0, 7));
         if (mode == 4) begin
            do bad = 8'($urandom);
            while (bad[7:2] == 6'b101000);
            fb[0] = bad;
         end
         for (int i = 0; i < 5; i++) begin
            if (mode == 5 && i == idx)
               send_bad_stop(fb[i]);
            else
               send_byte(fb[i]);
            if (mode == 6 && i == idx)
               idle_gap(21);
         end
         repeat (4) tick();
         check_msg("rnd_rx");
         if (m.nmr) begin
            repeat ($urandom_range(0, 6)) tick();
            check_msg("rnd_hold");
            ack_pulse();
            check_msg("rnd_ack");
         end
         idle_gap(25);
      end
      check_msg("final");
`ifdef COMM_RX_STATS_EN
      check_stats("final");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
